univ_shift_reg: RTL

Parametrised universal shift register, the successor to the team's fixed 4-bit left-shift register. It is WIDTH bits wide and supports left/right logical shift, rotate, arithmetic right shift, parallel load and clear. It adds a counted burst mode: one start pulse performs nbits shifts autonomously, with busy/done status. It sits between parallel datapaths and serial links, acting as a serializer/deserializer or barrel-step unit.

---
 rtl/univ_shift_reg_pkg.sv | 16 +
 rtl/univ_shift_reg_shift_unit.sv | 28 ++
 rtl/univ_shift_reg.sv | 76 +++++++
 3 files changed

// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_pkg: mode encodings, FSM state encoding and shift-mode helper for univ_shift_reg
package univ_shift_pkg;
   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_SHL   = 3'b001;
   localparam logic [2:0] MODE_SHR   = 3'b010;
   localparam logic [2:0] MODE_ROTL  = 3'b011;
   localparam logic [2:0] MODE_ROTR  = 3'b100;
   localparam logic [2:0] MODE_ASR   = 3'b101;
   localparam logic [2:0] MODE_LOAD  = 3'b110;
   localparam logic [2:0] MODE_CLEAR = 3'b111;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;
   function automatic logic is_shift(input logic [2:0] m);
      return (m >= MODE_SHL) && (m <= MODE_ASR);
   endfunction
endpackage

// File: rtl/univ_shift_reg_shift_unit.sv
// shift_unit: combinational next-value for the register
//   q, op, sin_l, sin_r, d_par in; next_q out
module shift_unit
   import univ_shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [2:0]       op,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic [WIDTH-1:0] d_par,
   output logic [WIDTH-1:0] next_q
);
   always_comb begin
      next_q = q;
      case (op)
         MODE_SHL:   next_q = {q[WIDTH-2:0], sin_r};
         MODE_SHR:   next_q = {sin_l, q[WIDTH-1:1]};
         MODE_ROTL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
         MODE_ROTR:  next_q = {q[0], q[WIDTH-1:1]};
         MODE_ASR:   next_q = {q[WIDTH-1], q[WIDTH-1:1]};
         MODE_LOAD:  next_q = d_par;
         MODE_CLEAR: next_q = '0;
         default:    next_q = q;
      endcase
   end
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with counted burst mode
//   clk, rst (async active-low), en, mode, d_par, sin_r, sin_l, start, nbits, abort in
//   q, sout_l, sout_r, busy, done out
module univ_shift_reg
   import univ_shift_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d_par,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic             start,
   input  logic [CNT_W-1:0] nbits,
   input  logic             abort,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
);
   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       lmode;
   logic [2:0]       op;
   logic [WIDTH-1:0] next_q;
   logic             go;
   // during a burst the latched mode drives the shifter, live mode is ignored
   assign op     = (state == ST_BUSY) ? lmode : mode;
   assign go     = start && is_shift(mode) && (nbits != '0);
   assign busy   = (state == ST_BUSY);
   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];
   shift_unit #(.WIDTH(WIDTH)) u_shift (
      .q(q), .op(op), .sin_l(sin_l), .sin_r(sin_r), .d_par(d_par), .next_q(next_q)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q     <= '0;
         state <= ST_IDLE;
         cnt   <= '0;
         lmode <= MODE_HOLD;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         // abort wins over en and skips the shift on its edge
         if (state == ST_BUSY && abort) begin
            state <= ST_IDLE;
            cnt   <= '0;
         end else if (en) begin
            q <= next_q;
            if (state == ST_IDLE) begin
               if (go) begin
                  lmode <= mode;
                  if (nbits == CNT_W'(1))
                     done <= 1'b1;
                  else begin
                     cnt   <= nbits - CNT_W'(1);
                     state <= ST_BUSY;
                  end
               end
            end else begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end
            end
         end
      end
   end
endmodule
